md_sequencer: RTL

//  Sequencer for the HI/LO multiply/divide resource in the E stage of the 5-stage MIPS pipeline.

---
 rtl/md_defs_pkg.sv | 32 +++
 rtl/md_alu.sv | 48 ++++
 rtl/md_sequencer.sv | 87 ++++++++
 3 files changed

// File: rtl/md_defs_pkg.sv
// Shared op-codes, state encodings and helpers for the HI/LO
// multiply/divide sequencer.
package md_defs;

  localparam int MD_OP_W = 3;

  localparam logic [MD_OP_W-1:0] MD_NONE  = 3'd0;
  localparam logic [MD_OP_W-1:0] MD_MULT  = 3'd1;
  localparam logic [MD_OP_W-1:0] MD_MULTU = 3'd2;
  localparam logic [MD_OP_W-1:0] MD_DIV   = 3'd3;
  localparam logic [MD_OP_W-1:0] MD_DIVU  = 3'd4;
  localparam logic [MD_OP_W-1:0] MD_MTHI  = 3'd5;
  localparam logic [MD_OP_W-1:0] MD_MTLO  = 3'd6;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } md_state_t;

  function automatic logic is_md_issue(
    input logic [MD_OP_W-1:0] op
  );
    return (op >= MD_MULT) && (op <= MD_DIVU);
  endfunction

  function automatic logic is_div(
    input logic [MD_OP_W-1:0] op
  );
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_alu.sv
// Combinational mult/div datapath producing {hi,lo} and a
// divide-by-zero flag.
module md_alu
  import md_defs::*;
(
  input  logic [MD_OP_W-1:0] op,
  input  logic [31:0]        rs,
  input  logic [31:0]        rt,
  output logic [63:0]        res,
  output logic               div_zero
);

  logic signed [31:0] sa;
  logic signed [31:0] sb;
  logic signed [31:0] sq;
  logic signed [31:0] sr;
  logic [31:0] ub;
  logic [31:0] uq;
  logic [31:0] ur;
  logic [63:0] sp;
  logic [63:0] up;
  logic        ovf;

  always_comb begin
    ovf = (rs == 32'h8000_0000) && (rt == 32'hFFFF_FFFF);
    // divisor 1 stands in for /0 and for the overflow case,
    // which then yields q=0x80000000, r=0 as required
    sa = rs;
    sb = ((rt == 32'd0) || ovf) ? 32'sd1 : rt;
    sq = sa / sb;
    sr = sa % sb;
    ub = (rt == 32'd0) ? 32'd1 : rt;
    uq = rs / ub;
    ur = rs % ub;
    sp = {{32{rs[31]}}, rs} * {{32{rt[31]}}, rt};
    up = {32'd0, rs} * {32'd0, rt};
    div_zero = is_div(op) && (rt == 32'd0);
    res = '0;
    unique case (1'b1)
      op == MD_MULT:  res = sp;
      op == MD_MULTU: res = up;
      op == MD_DIV:   res = {sr, sq};
      op == MD_DIVU:  res = {ur, uq};
      default:        res = '0;
    endcase
  end

endmodule

// File: rtl/md_sequencer.sv
// HI/LO multiply/divide sequencer: fixed-latency issue, busy
// reporting and HI/LO commit for the E stage.
module md_sequencer
  import md_defs::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [MD_OP_W-1:0] md_op,
  input  logic               start,
  input  logic               flush,
  input  logic [31:0]        rs_data,
  input  logic [31:0]        rt_data,
  output logic               busy,
  output logic [31:0]        hi,
  output logic [31:0]        lo
);

  localparam int MAXC =
    (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAXC + 1);

  md_state_t          state;
  logic [CW-1:0]      count;
  logic [MD_OP_W-1:0] op_q;
  logic [31:0]        rs_q;
  logic [31:0]        rt_q;
  logic [63:0]        res;
  logic               div_zero;

  md_alu u_alu (
    .op       (op_q),
    .rs       (rs_q),
    .rt       (rt_q),
    .res      (res),
    .div_zero (div_zero)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= S_IDLE;
      busy  <= 1'b0;
      count <= '0;
      op_q  <= MD_NONE;
      rs_q  <= '0;
      rt_q  <= '0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start && !flush && is_md_issue(md_op)) begin
            state <= S_RUN;
            busy  <= 1'b1;
            op_q  <= md_op;
            rs_q  <= rs_data;
            rt_q  <= rt_data;
            count <= is_div(md_op) ? CW'(DIV_CYCLES)
                                   : CW'(MULT_CYCLES);
          end else if (!flush && md_op == MD_MTHI) begin
            hi <= rs_data;
          end else if (!flush && md_op == MD_MTLO) begin
            lo <= rs_data;
          end
        end
        S_RUN: begin
          count <= count - CW'(1);
          if (count == CW'(1)) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            if (!div_zero) begin
              hi <= res[63:32];
              lo <= res[31:0];
            end
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
